// File: rtl/mem_io_stage_if.sv
// IO bus between the MEM-stage access unit (master) and an IO responder (slave).
// The request side is held stable until the responder acks or the master times out.
interface mem_io_stage_if;
  logic        io_req_o;
  logic        io_we_o;
  logic [31:0] io_addr_o;
  logic [31:0] io_wdata_o;
  logic        io_ack_i;
  logic [31:0] io_rdata_i;

  modport master (
    output io_req_o, io_we_o, io_addr_o, io_wdata_o,
    input  io_ack_i, io_rdata_i
  );

  modport slave (
    input  io_req_o, io_we_o, io_addr_o, io_wdata_o,
    output io_ack_i, io_rdata_i
  );
endinterface

// File: rtl/mem_io_stage.sv
// MEM-stage access unit: byte/half/word RAM loads and stores, req/ack IO transactions
// with timeout, front-pipeline stall and registered, aligned write-back data.
module mem_io_stage #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              io_read_i,
  input  logic              io_write_i,
  input  logic [1:0]        byte_or_word_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       rdata2_i,
  input  logic [4:0]        rd_i,
  output logic              stall_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_we_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic [31:0]       dmem_rdata_i,
  mem_io_stage_if.master    io,
  output logic              reg_write_o,
  output logic [4:0]        rd_o,
  output logic [31:0]       wb_data_o,
  output logic              misalign_o,
  output logic              io_err_o
);

  typedef enum logic [1:0] {IDLE, MEM_RD, IO_WAIT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(IO_TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lo;
  logic        lat_rw;
  logic [4:0]  lat_rd;
  logic        lat_io_rd;

  logic mis, go_io, go_mrd, go_mwr, tmo_hit;

  function automatic logic [31:0] align_load(input logic [31:0] w,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   align_load = {{24{b[7]}}, b};
      2'b01:   align_load = {{16{h[15]}}, h};
      2'b10:   align_load = w;
      default: align_load = {24'b0, b};
    endcase
  endfunction

  assign dmem_addr_o = alu_result_i[ADDR_W+1:2];

  always_comb begin
    mis = ((byte_or_word_i == 2'b01) && alu_result_i[0]) ||
          ((byte_or_word_i == 2'b10) && (alu_result_i[1:0] != 2'b00));
    // Priority io_read > io_write > mem_read > mem_write; a misaligned access is dropped.
    go_io   = (io_read_i | io_write_i) & ~mis;
    go_mrd  = ~io_read_i & ~io_write_i & mem_read_i & ~mis;
    go_mwr  = ~io_read_i & ~io_write_i & ~mem_read_i & mem_write_i & ~mis;
    tmo_hit = (state == IO_WAIT) && !io.io_ack_i && (tmo_cnt == TMO_LAST);
  end

  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = go_mrd | go_io;
      IO_WAIT: stall_o = ~io.io_ack_i & ~tmo_hit;
      default: stall_o = 1'b0;
    endcase
    // Stall must read 0 while held in reset, whatever the pipeline presents.
    stall_o = stall_o & rst_n;
  end

  always_comb begin
    dmem_we_o    = '0;
    dmem_wdata_o = rdata2_i;
    case (byte_or_word_i)
      2'b01:   dmem_wdata_o = {2{rdata2_i[15:0]}};
      2'b10:   dmem_wdata_o = rdata2_i;
      default: dmem_wdata_o = {4{rdata2_i[7:0]}};
    endcase
    if (rst_n && state == IDLE && go_mwr) begin
      case (byte_or_word_i)
        2'b01:   dmem_we_o = alu_result_i[1] ? 4'b1100 : 4'b0011;
        2'b10:   dmem_we_o = 4'b1111;
        default: dmem_we_o = 4'b0001 << alu_result_i[1:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      lat_size      <= '0;
      lat_lo        <= '0;
      lat_rw        <= 1'b0;
      lat_rd        <= '0;
      lat_io_rd     <= 1'b0;
      io.io_req_o   <= 1'b0;
      io.io_we_o    <= 1'b0;
      io.io_addr_o  <= '0;
      io.io_wdata_o <= '0;
      reg_write_o   <= 1'b0;
      rd_o          <= '0;
      wb_data_o     <= '0;
      misalign_o    <= 1'b0;
      io_err_o      <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      io_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          lat_size  <= byte_or_word_i;
          lat_lo    <= alu_result_i[1:0];
          lat_rw    <= reg_write_i;
          lat_rd    <= rd_i;
          lat_io_rd <= io_read_i;
          if (mis && (io_read_i | io_write_i | mem_read_i | mem_write_i)) begin
            misalign_o  <= 1'b1;
            reg_write_o <= 1'b0;
            rd_o        <= '0;
          end else if (go_io) begin
            io.io_req_o   <= 1'b1;
            io.io_we_o    <= ~io_read_i;
            io.io_addr_o  <= alu_result_i;
            io.io_wdata_o <= rdata2_i;
            reg_write_o   <= 1'b0;
            rd_o          <= '0;
            state         <= IO_WAIT;
          end else if (go_mrd) begin
            reg_write_o <= 1'b0;
            rd_o        <= '0;
            state       <= MEM_RD;
          end else begin
            reg_write_o <= reg_write_i;
            rd_o        <= reg_write_i ? rd_i : 5'd0;
            wb_data_o   <= alu_result_i;
          end
        end
        MEM_RD: begin
          wb_data_o   <= align_load(dmem_rdata_i, lat_size, lat_lo);
          reg_write_o <= lat_rw;
          rd_o        <= lat_rw ? lat_rd : 5'd0;
          state       <= IDLE;
        end
        IO_WAIT: begin
          if (io.io_ack_i) begin
            io.io_req_o <= 1'b0;
            io.io_we_o  <= 1'b0;
            tmo_cnt     <= '0;
            if (lat_io_rd) begin
              wb_data_o   <= align_load(io.io_rdata_i, lat_size, lat_lo);
              reg_write_o <= lat_rw;
              rd_o        <= lat_rw ? lat_rd : 5'd0;
            end else begin
              reg_write_o <= 1'b0;
              rd_o        <= '0;
            end
            state <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            io.io_req_o <= 1'b0;
            io.io_we_o  <= 1'b0;
            tmo_cnt     <= '0;
            io_err_o    <= 1'b1;
            wb_data_o   <= '0;
            reg_write_o <= lat_io_rd & lat_rw;
            rd_o        <= (lat_io_rd & lat_rw) ? lat_rd : 5'd0;
            state       <= IDLE;
          end else begin
            tmo_cnt     <= tmo_cnt + 16'd1;
            reg_write_o <= 1'b0;
            rd_o        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_stage.sv
// Directed-vector bench for mem_io_stage with a small synchronous-read RAM model.
module tb_mem_io_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write_i, mem_read_i, mem_write_i, io_read_i, io_write_i;
  logic [1:0]  byte_or_word_i;
  logic [31:0] alu_result_i, rdata2_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic [13:0] dmem_addr_o;
  logic [3:0]  dmem_we_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        reg_write_o;
  logic [4:0]  rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o, io_err_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] ram [16];

  mem_io_stage_if io_bus ();

  mem_io_stage #(.ADDR_W(14), .IO_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .io_read_i(io_read_i), .io_write_i(io_write_i), .byte_or_word_i(byte_or_word_i),
    .alu_result_i(alu_result_i), .rdata2_i(rdata2_i), .rd_i(rd_i),
    .stall_o(stall_o), .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .io(io_bus),
    .reg_write_o(reg_write_o), .rd_o(rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .io_err_o(io_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dmem_we_o[i]) ram[dmem_addr_o[3:0]][8*i +: 8] <= dmem_wdata_o[8*i +: 8];
    dmem_rdata_i <= ram[dmem_addr_o[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, mr, mw, ir, iw, input logic [1:0] bw,
                       input logic [31:0] alu, d2, input logic [4:0] rd);
    reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
    io_read_i = ir; io_write_i = iw; byte_or_word_i = bw;
    alu_result_i = alu; rdata2_i = d2; rd_i = rd;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] bw, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, bw, addr, 32'h0, rd);
    #1 check({tag, "_stall1"}, 32'(stall_o), 32'd1);
    step();
    check({tag, "_stall2"}, 32'(stall_o), 32'd0);
    check({tag, "_bubble"}, 32'(reg_write_o), 32'd0);
    step();
    check({tag, "_data"}, wb_data_o, exp);
    check({tag, "_rw"}, 32'(reg_write_o), 32'd1);
    check({tag, "_rd"}, 32'(rd_o), 32'(rd));
    nop();
  endtask

  task automatic do_store(input string tag, input logic [1:0] bw, input logic [31:0] addr,
                          input logic [31:0] d, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, bw, addr, d, 5'd0);
    #1 check({tag, "_we"}, 32'(dmem_we_o), 32'(exp_we));
    check({tag, "_wdata"}, dmem_wdata_o, exp_wd);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    step();
    nop();
  endtask

  initial begin
    rst_n = 1'b0;
    io_bus.io_ack_i = 1'b0;
    io_bus.io_rdata_i = 32'h0;
    nop();
    step();
    step();
    check("rst_req", 32'(io_bus.io_req_o), 32'd0);
    check("rst_rw", 32'(reg_write_o), 32'd0);
    check("rst_wb", wb_data_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_err", 32'({misalign_o, io_err_o}), 32'd0);
    rst_n = 1'b1;
    step();

    // word store/load
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 5'd0);
    #1 check("sw_addr", 32'(dmem_addr_o), 32'd4);
    do_store("sw", 2'b10, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_load("lw", 2'b10, 32'h10, 5'd5, 32'hDEADBEEF);

    // byte store then signed/unsigned byte loads
    do_store("sb", 2'b00, 32'h13, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    do_load("lb", 2'b00, 32'h13, 5'd6, 32'hFFFFFFA5);
    do_load("lbu", 2'b11, 32'h13, 5'd6, 32'h000000A5);
    do_load("lb0", 2'b00, 32'h10, 5'd6, 32'hFFFFFFEF);

    // halfword
    do_store("sh", 2'b01, 32'h16, 32'h00001234, 4'b1100, 32'h12341234);
    do_store("sw2", 2'b10, 32'h10, 32'h80017FFF, 4'b1111, 32'h80017FFF);
    do_load("lh_hi", 2'b01, 32'h12, 5'd8, 32'hFFFF8001);
    do_load("lh_lo", 2'b01, 32'h10, 5'd8, 32'h00007FFF);

    // misaligned half load and word store
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h11, 32'h0, 5'd8);
    #1 check("mis_lh_stall", 32'(stall_o), 32'd0);
    step();
    check("mis_lh_pulse", 32'(misalign_o), 32'd1);
    check("mis_lh_rw", 32'(reg_write_o), 32'd0);
    check("mis_lh_rd", 32'(rd_o), 32'd0);
    nop();
    step();
    check("mis_lh_clr", 32'(misalign_o), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h12, 32'h11111111, 5'd0);
    #1 check("mis_sw_we", 32'(dmem_we_o), 32'd0);
    step();
    check("mis_sw_pulse", 32'(misalign_o), 32'd1);
    nop();
    step();

    // IO read acked in the third request cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'hFFFFFC70, 32'h0, 5'd7);
    #1 check("ior_stall0", 32'(stall_o), 32'd1);
    check("ior_req0", 32'(io_bus.io_req_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 2) begin
        io_bus.io_ack_i = 1'b1;
        io_bus.io_rdata_i = 32'h00000123;
        #1;
      end
      check("ior_req", 32'(io_bus.io_req_o), 32'd1);
      check("ior_addr", io_bus.io_addr_o, 32'hFFFFFC70);
      check("ior_stall", 32'(stall_o), (c == 2) ? 32'd0 : 32'd1);
    end
    step();
    io_bus.io_ack_i = 1'b0;
    check("ior_req_end", 32'(io_bus.io_req_o), 32'd0);
    check("ior_wb", wb_data_o, 32'h00000123);
    check("ior_rw", 32'(reg_write_o), 32'd1);
    check("ior_rd", 32'(rd_o), 32'd7);
    nop();
    step();

    // IO write with no ack times out after 4 request cycles
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h40, 32'h000055AA, 5'd0);
    step();
    check("iow_we", 32'(io_bus.io_we_o), 32'd1);
    check("iow_wdata", io_bus.io_wdata_o, 32'h000055AA);
    for (int c = 0; c < 4; c++) begin
      check("iow_req", 32'(io_bus.io_req_o), 32'd1);
      check("iow_stall", 32'(stall_o), (c == 3) ? 32'd0 : 32'd1);
      check("iow_err_early", 32'(io_err_o), 32'd0);
      step();
    end
    check("iow_req_end", 32'(io_bus.io_req_o), 32'd0);
    check("iow_err", 32'(io_err_o), 32'd1);
    check("iow_rw", 32'(reg_write_o), 32'd0);
    nop();
    step();
    check("iow_err_clr", 32'(io_err_o), 32'd0);
    check("iow_idle_stall", 32'(stall_o), 32'd0);

    // IO write acked in the very first request cycle
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h44, 32'h00000077, 5'd0);
    step();
    io_bus.io_ack_i = 1'b1;
    #1 check("ack1_stall", 32'(stall_o), 32'd0);
    step();
    io_bus.io_ack_i = 1'b0;
    check("ack1_req", 32'(io_bus.io_req_o), 32'd0);
    check("ack1_rw", 32'(reg_write_o), 32'd0);
    nop();

    // plain ALU write-back
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h00001234, 32'h0, 5'd2);
    step();
    check("alu_wb", wb_data_o, 32'h00001234);
    check("alu_rd", 32'(rd_o), 32'd2);

    // reset in the middle of an IO transaction
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h48, 32'h0, 5'd9);
    step();
    check("rio_req", 32'(io_bus.io_req_o), 32'd1);
    rst_n = 1'b0;
    #1 check("rio_req_drop", 32'(io_bus.io_req_o), 32'd0);
    check("rio_stall", 32'(stall_o), 32'd0);
    check("rio_wb", wb_data_o, 32'd0);
    check("rio_rw", 32'(reg_write_o), 32'd0);
    nop();
    #2 rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'd7, 32'h0, 5'd3);
    step();
    check("post_wb", wb_data_o, 32'd7);
    check("post_rd", 32'(rd_o), 32'd3);
    check("post_rw", 32'(reg_write_o), 32'd1);
    nop();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_io_stage.md
Name:
mem_io_stage

Overview:
MEM-stage access unit driven by the EX/MEM pipeline register outputs. It performs byte, halfword and word loads and stores to a synchronous-read data RAM, and runs a req/ack transaction on the IO bus. It stalls the front pipeline while an access is outstanding and presents registered write-back data (aligned and extended) to the MEM/WB side.

Parameters:
ADDR_W, 14, data RAM word-address width; dmem_addr_o = alu_result_i[ADDR_W+1:2]
IO_TIMEOUT, 255, IO_WAIT cycles without ack before the transaction is aborted (1..65535)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
reg_write_i  in  1  instruction writes rd
mem_read_i / mem_write_i  in  1 each  RAM load / store
io_read_i / io_write_i  in  1 each  IO load / store
byte_or_word_i  in  2  00 byte signed, 01 half signed, 10 word, 11 byte unsigned
alu_result_i  in  32  effective address, or ALU result for non-load write-back
rdata2_i  in  32  store data
rd_i  in  5  destination register
stall_o  out  1  combinational; 1 = EX/MEM and earlier stages hold
dmem_addr_o  out  ADDR_W  RAM word address (combinational)
dmem_we_o  out  4  byte write enables (combinational)
dmem_wdata_o  out  32  lane-replicated store data
dmem_rdata_i  in  32  RAM read data, valid 1 cycle after address
io_req_o  out  1  IO request, registered
io_we_o  out  1  IO write when 1, registered
io_addr_o / io_wdata_o  out  32 each  held stable while io_req_o=1
io_ack_i  in  1  responder completes the transaction in this cycle
io_rdata_i  in  32  valid when io_ack_i=1
reg_write_o  out  1  registered write-back enable
rd_o  out  5  registered
wb_data_o  out  32  registered write-back data
misalign_o  out  1  registered 1-cycle pulse
io_err_o  out  1  registered 1-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0; every registered output 0; stall_o=0. io_req_o drops immediately on reset, including mid-transaction.
- Priority when several flags are set: io_read > io_write > mem_read > mem_write.
- Alignment: a halfword with addr[0]=1, or a word with addr[1:0]!=0, is misaligned. The access is suppressed (we=0, no IO request). On the next edge misalign_o=1 and reg_write_o=0. There is no stall.
- Stores: byte → we=1<<addr[1:0], data replicated x4. Half → we=0011 (addr[1]=0) or 1100, data replicated x2. Word → 1111. A store issues in IDLE within the same cycle, with no stall.
- Load lane select: byte uses addr[1:0], half uses addr[1]. The result is sign- or zero-extended per byte_or_word_i.
- IDLE:
  - mem_read → drive address, stall_o=1, go MEM_RD.
  - io_* → stall_o=1; next edge sets io_req_o=1 with addr/wdata/we latched; go IO_WAIT.
  - Otherwise → next edge sets reg_write_o=reg_write_i and wb_data_o=alu_result_i.
- MEM_RD: stall_o=0. The edge writes the aligned dmem_rdata_i to wb_data_o with reg_write_o=reg_write_i, then returns to IDLE. Load latency is 2 cycles.
- IO_WAIT: stall_o = ~io_ack_i.
  - On ack: the edge clears io_req_o. For a read, wb_data_o = aligned io_rdata_i; for a write, reg_write_o=0. Go IDLE.
  - Counter increments every IO_WAIT cycle without ack. When it reaches IO_TIMEOUT: stall_o=0, io_req_o cleared, io_err_o pulses, wb_data_o=0, reg_write_o=reg_write_i for reads. Go IDLE.
  - Counter clears on leaving IO_WAIT.
- Any stalled cycle writes a bubble: reg_write_o=0.
- rd_o=0 whenever reg_write_o=0.
- ack arriving in the same cycle io_req_o first rises is legal and completes that cycle.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 → we=1111 with dmem_addr=4; load has stall_o=1 for 1 cycle, then wb_data_o=0xDEADBEEF, reg_write_o=1.
- Byte store 0x000000A5 @0x13, then byte load signed and byte load unsigned @0x13 → we=1000, wdata=0xA5A5A5A5; loads give 0xFFFFFFA5 and 0x000000A5.
- Half load @0x12 with RAM word 0x8001_7FFF → 0xFFFF8001; half load @0x11 → misalign_o pulse, reg_write_o=0, no stall.
- IO read @0xFFFFFC70, ack after 3 cycles with 0x0000_0123 → io_req_o high 3 cycles, addr stable, stall_o released in ack cycle, wb_data_o=0x123.
- IO write, no ack, IO_TIMEOUT=4 → io_req_o high 4 cycles, io_err_o pulses once, reg_write_o=0, FSM back in IDLE.
- rst_n=0 asserted during IO_WAIT → io_req_o, stall_o and all outputs go to 0 immediately; after release, ALU instruction with alu_result_i=7, rd_i=3 gives wb_data_o=7, rd_o=3 one edge later.
